// File: rtl/decode_queue.sv
// decode_queue: RV32I instruction decoder feeding a small FIFO of decoded entries.
// Instructions are decoded combinationally and pushed into the FIFO when accepted.
// The FIFO head drives the out_* fields.
// Ports:
//   clk, rst (sync, active-low), flush
//   in_valid/in_ready, in_instr, in_pc        : fetch-side handshake
//   out_valid/out_ready, out_* decoded fields : execute-side handshake (FIFO head)
//   illegal_count                             : saturating count of accepted illegal instructions
module decode_queue #(
    parameter int DEPTH       = 2,
    parameter bit ENABLE_MEM  = 1'b1,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [2:0]           out_encoding,
    output logic [3:0]           out_alu_op,
    output logic                 out_reg_write,
    output logic                 out_alu_src,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic                 out_mem_to_reg,
    output logic                 out_branch,
    output logic                 out_jump,
    output logic [31:0]          out_imm,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam logic [2:0] ENC_R = 3'd0, ENC_I = 3'd1, ENC_S = 3'd2,
                           ENC_B = 3'd3, ENC_U = 3'd4, ENC_J = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                           ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                           ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                           ALU_AND = 4'd9, ALU_LUI = 4'd10;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                           OP_B = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    localparam int         PTR_W    = $clog2(DEPTH);
    localparam int         ENTRY_W  = 94;
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

    // funct3 -> ALU op for OP/OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f_alu = ALU_SLL;
            3'b010:  f_alu = ALU_SLT;
            3'b011:  f_alu = ALU_SLTU;
            3'b100:  f_alu = ALU_XOR;
            3'b101:  f_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f_alu = ALU_OR;
            default: f_alu = ALU_AND;
        endcase
    endfunction

    logic [6:0]  w_opcode, w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [2:0]  w_enc;
    logic [3:0]  w_alu;
    logic [6:0]  w_ctl;   // {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump}
    logic [31:0] w_imm;
    logic        w_ill;
    logic [ENTRY_W-1:0] w_entry, w_head;
    logic        w_push, w_pop;

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]       r_occ;
    logic [CNT_WIDTH-1:0] r_illegal_count;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        w_enc = ENC_R;
        w_alu = ALU_ADD;
        w_ctl = 7'b0;
        w_imm = 32'b0;
        w_ill = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_enc = ENC_R;
                w_ctl = 7'b1000000;
                w_alu = f_alu(w_f3, w_f7[5]);
                if (!(w_f7 == 7'b0000000 ||
                      (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    w_ill = 1'b1;
            end
            OP_I: begin
                w_enc = ENC_I;
                w_ctl = 7'b1100000;
                w_imm = w_imm_i;
                // Only the right-shift form uses funct7[5]; ADDI has no SUB variant.
                w_alu = f_alu(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000)
                    w_ill = 1'b1;
                if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
                    w_ill = 1'b1;
            end
            OP_LUI: begin
                w_enc = ENC_U;
                w_ctl = 7'b1000000;
                w_alu = ALU_LUI;
                w_imm = w_imm_u;
            end
            OP_B: begin
                w_enc = ENC_B;
                w_ctl = 7'b0000010;
                w_imm = w_imm_b;
                case (w_f3[2:1])
                    2'b00:   w_alu = ALU_SUB;
                    2'b10:   w_alu = ALU_SLT;
                    2'b11:   w_alu = ALU_SLTU;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_enc = ENC_I;
                w_ctl = 7'b1110100;
                w_imm = w_imm_i;
                w_ill = (w_f3 != 3'b010) || !ENABLE_MEM;
            end
            OP_STORE: begin
                w_enc = ENC_S;
                w_ctl = 7'b0101000;
                w_imm = w_imm_s;
                w_ill = (w_f3 != 3'b010) || !ENABLE_MEM;
            end
            OP_JAL: begin
                w_enc = ENC_J;
                w_ctl = 7'b1000001;
                w_imm = w_imm_j;
                w_ill = !ENABLE_JUMP;
            end
            OP_JALR: begin
                w_enc = ENC_I;
                w_ctl = 7'b1100001;
                w_imm = w_imm_i;
                w_ill = (w_f3 != 3'b000) || !ENABLE_JUMP;
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal entries carry neutral control so downstream can never act on them.
        if (w_ill) begin
            w_enc = ENC_R;
            w_alu = ALU_ADD;
            w_ctl = 7'b0;
            w_imm = 32'b0;
        end
    end

    assign w_entry = {in_pc, in_instr[19:15], in_instr[24:20], in_instr[11:7],
                      w_enc, w_alu, w_ctl, w_imm, w_ill};

    assign in_ready  = (r_occ != OCC_FULL);
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
            else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push)
            r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_illegal_count <= '0;
        else if (w_push && w_ill && r_illegal_count != '1)
            r_illegal_count <= r_illegal_count + 1'b1;
    end

    assign illegal_count = r_illegal_count;

    // Stale storage is masked so every field reads zero while empty.
    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

    assign {out_pc, out_rs1, out_rs2, out_rd, out_encoding, out_alu_op,
            out_reg_write, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg,
            out_branch, out_jump, out_imm, out_illegal} = w_head;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

    localparam int DEPTH = 2;

    localparam logic [2:0] E_R = 3'd0, E_I = 3'd1, E_S = 3'd2, E_B = 3'd3, E_U = 3'd4, E_J = 3'd5;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                           A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9,
                           A_LUI = 4'd10;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  enc;
        logic [3:0]  alu;
        logic [6:0]  ctl;  // reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
        logic        ill2;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic in_ready, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [4:0] out_rs1, out_rs2, out_rd;
    logic [2:0] out_encoding;
    logic [3:0] out_alu_op;
    logic out_reg_write, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_jump, out_illegal;
    logic [15:0] illegal_count;

    logic in_ready2, out_valid2;
    logic [31:0] o2_pc, o2_imm;
    logic [4:0] o2_rs1, o2_rs2, o2_rd;
    logic [2:0] o2_enc;
    logic [3:0] o2_alu;
    logic o2_rw, o2_as, o2_mr, o2_mw, o2_m2r, o2_br, o2_jmp, o2_ill;
    logic [1:0] illegal_count2;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_encoding(out_encoding), .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
        .out_alu_src(out_alu_src), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch), .out_jump(out_jump),
        .out_imm(out_imm), .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    decode_queue #(.DEPTH(DEPTH), .ENABLE_MEM(1'b0), .ENABLE_JUMP(1'b0), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid2), .out_ready(out_ready),
        .out_pc(o2_pc), .out_rs1(o2_rs1), .out_rs2(o2_rs2), .out_rd(o2_rd),
        .out_encoding(o2_enc), .out_alu_op(o2_alu), .out_reg_write(o2_rw),
        .out_alu_src(o2_as), .out_mem_read(o2_mr), .out_mem_write(o2_mw),
        .out_mem_to_reg(o2_m2r), .out_branch(o2_br), .out_jump(o2_jmp),
        .out_imm(o2_imm), .out_illegal(o2_ill), .illegal_count(illegal_count2)
    );

    int n_chk = 0, n_err = 0;
    dec_t q1[$], q2[$];
    int cnt1 = 0, cnt2 = 0;

    function automatic dec_t act1();
        return {out_pc, out_rs1, out_rs2, out_rd, out_encoding, out_alu_op,
                out_reg_write, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg,
                out_branch, out_jump, out_imm, out_illegal};
    endfunction

    function automatic dec_t act2();
        return {o2_pc, o2_rs1, o2_rs2, o2_rd, o2_enc, o2_alu, o2_rw, o2_as, o2_mr, o2_mw,
                o2_m2r, o2_br, o2_jmp, o2_imm, o2_ill};
    endfunction

    function automatic dec_t mk(logic [31:0] pc, int rs1, int rs2, int rd, logic [2:0] enc,
                                logic [3:0] alu, logic [6:0] ctl, logic [31:0] imm, logic ill);
        dec_t d;
        d.pc = pc; d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.rd = 5'(rd);
        d.enc = enc; d.alu = alu; d.ctl = ctl; d.imm = imm; d.ill = ill;
        return d;
    endfunction

    // Reference decode straight from the ISA rules.
    function automatic dec_t ref_dec(logic [31:0] ins, logic [31:0] pc, bit em, bit ej);
        dec_t d;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        int imm_i = $signed(ins[31:20]);
        int imm_s = $signed({ins[31:25], ins[11:7]});
        int imm_b = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        int imm_j = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        logic [3:0] alu_tab [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        bit bad = 0;
        d = mk(pc, ins[19:15], ins[24:20], ins[11:7], E_R, A_ADD, 7'b0, 32'd0, 1'b0);
        case (ins[6:0])
            7'h33: begin
                d.enc = E_R; d.ctl = 7'b1000000; d.alu = alu_tab[f3];
                if (f7 == 7'h20 && f3 == 3'd0) d.alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) d.alu = A_SRA;
                else if (f7 != 7'h00) bad = 1;
            end
            7'h13: begin
                d.enc = E_I; d.ctl = 7'b1100000; d.imm = imm_i; d.alu = alu_tab[f3];
                if (f3 == 3'd1 && f7 != 7'h00) bad = 1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) d.alu = A_SRA;
                    else if (f7 != 7'h00) bad = 1;
                end
            end
            7'h37: begin d.enc = E_U; d.ctl = 7'b1000000; d.alu = A_LUI; d.imm = ins & 32'hFFFFF000; end
            7'h63: begin
                d.enc = E_B; d.ctl = 7'b0000010; d.imm = imm_b;
                if (f3 == 3'd2 || f3 == 3'd3) bad = 1;
                else if (f3 < 3'd2) d.alu = A_SUB;
                else if (f3 < 3'd6) d.alu = A_SLT;
                else d.alu = A_SLTU;
            end
            7'h03: begin d.enc = E_I; d.ctl = 7'b1110100; d.imm = imm_i; bad = (f3 != 3'd2) || !em; end
            7'h23: begin d.enc = E_S; d.ctl = 7'b0101000; d.imm = imm_s; bad = (f3 != 3'd2) || !em; end
            7'h6F: begin d.enc = E_J; d.ctl = 7'b1000001; d.imm = imm_j; bad = !ej; end
            7'h67: begin d.enc = E_I; d.ctl = 7'b1100001; d.imm = imm_i; bad = (f3 != 3'd0) || !ej; end
            default: bad = 1;
        endcase
        if (bad) d = mk(pc, ins[19:15], ins[24:20], ins[11:7], E_R, A_ADD, 7'b0, 32'd0, 1'b1);
        return d;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        dec_t e1, e2;
        e1 = (q1.size() != 0) ? q1[0] : '0;
        e2 = (q2.size() != 0) ? q2[0] : '0;
        chk("out_valid", out_valid, q1.size() != 0);
        chk("in_ready", in_ready, q1.size() != DEPTH);
        chk("head", act1(), e1);
        chk("illegal_count", illegal_count, cnt1);
        chk("out_valid2", out_valid2, q2.size() != 0);
        chk("in_ready2", in_ready2, q2.size() != DEPTH);
        chk("head2", act2(), e2);
        chk("illegal_count2", illegal_count2, cnt2);
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rs);
        bit push, pop;
        dec_t d1, d2;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = rs;
        @(posedge clk);
        if (!rs) begin
            q1.delete(); q2.delete(); cnt1 = 0; cnt2 = 0;
        end else if (fl) begin
            q1.delete(); q2.delete();
        end else begin
            push = v && (q1.size() < DEPTH);
            pop  = ordy && (q1.size() > 0);
            if (pop) begin void'(q1.pop_front()); void'(q2.pop_front()); end
            if (push) begin
                d1 = ref_dec(ins, pc, 1'b1, 1'b1);
                d2 = ref_dec(ins, pc, 1'b0, 1'b0);
                q1.push_back(d1); q2.push_back(d2);
                if (d1.ill && cnt1 < 65535) cnt1++;
                if (d2.ill && cnt2 < 3) cnt2++;
            end
        end
        #1;
        check_all();
    endtask

    vec_t tv [15];
    logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h37, 7'h63, 7'h03, 7'h23, 7'h6F, 7'h67};

    initial begin
        logic [31:0] ins;
        logic [15:0] saved;
        tv[0]  = '{32'h00500093, mk(0, 0, 5, 1, E_I, A_ADD, 7'b1100000, 32'd5, 0), 0};
        tv[1]  = '{32'h402081B3, mk(0, 1, 2, 3, E_R, A_SUB, 7'b1000000, 32'd0, 0), 0};
        tv[2]  = '{32'hFE208EE3, mk(0, 1, 2, 29, E_B, A_SUB, 7'b0000010, 32'hFFFFFFFC, 0), 0};
        tv[3]  = '{32'h00812283, mk(0, 2, 8, 5, E_I, A_ADD, 7'b1110100, 32'd8, 0), 1};
        tv[4]  = '{32'h12345237, mk(0, 8, 3, 4, E_U, A_LUI, 7'b1000000, 32'h12345000, 0), 0};
        tv[5]  = '{32'h00000000, mk(0, 0, 0, 0, E_R, A_ADD, 7'b0, 32'd0, 1), 1};
        tv[6]  = '{32'hFFFFFFFF, mk(0, 31, 31, 31, E_R, A_ADD, 7'b0, 32'd0, 1), 1};
        tv[7]  = '{32'h00612623, mk(0, 2, 6, 12, E_S, A_ADD, 7'b0101000, 32'd12, 0), 1};
        tv[8]  = '{32'h010000EF, mk(0, 0, 16, 1, E_J, A_ADD, 7'b1000001, 32'd16, 0), 1};
        tv[9]  = '{32'h00008067, mk(0, 1, 0, 0, E_I, A_ADD, 7'b1100001, 32'd0, 0), 1};
        tv[10] = '{32'h4030D393, mk(0, 1, 3, 7, E_I, A_SRA, 7'b1100000, 32'h403, 0), 0};
        tv[11] = '{32'h40309393, mk(0, 1, 3, 7, E_R, A_ADD, 7'b0, 32'd0, 1), 1};
        tv[12] = '{32'hFE20AEE3, mk(0, 1, 2, 29, E_R, A_ADD, 7'b0, 32'd0, 1), 1};
        tv[13] = '{32'h00C5F533, mk(0, 11, 12, 10, E_R, A_AND, 7'b1000000, 32'd0, 0), 0};
        tv[14] = '{32'h40C59533, mk(0, 11, 12, 10, E_R, A_ADD, 7'b0, 32'd0, 1), 1};

        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);

        // Directed decode vectors, one accept then one idle cycle each.
        for (int i = 0; i < 15; i++) begin
            tv[i].exp.pc = 32'h1000 + 32'(i * 4);
            step(1, tv[i].instr, tv[i].exp.pc, 1, 0, 1);
            chk("tbl_decode", act1(), tv[i].exp);
            chk("tbl_illegal2", o2_ill, tv[i].ill2);
            if (i == 6) chk("cnt_after_zero_ones", illegal_count, 16'd2);
            step(0, 0, 0, 1, 0, 1);
        end
        chk("cnt_saturated_w2", illegal_count2, 2'd3);
        chk("cnt_total", illegal_count, 16'd5);

        // Back-to-back sub, beq: no bubble.
        step(1, 32'h402081B3, 32'h200, 1, 0, 1);
        step(1, 32'hFE208EE3, 32'h204, 1, 0, 1);
        chk("b2b_pc", out_pc, 32'h204);
        step(0, 0, 0, 1, 0, 1);

        // Backpressure: third push refused, head stable, then in-order drain.
        step(1, 32'h00500093, 32'h300, 0, 0, 1);
        step(1, 32'h402081B3, 32'h304, 0, 0, 1);
        chk("bp_full_in_ready", in_ready, 1'b0);
        step(1, 32'hFE208EE3, 32'h308, 0, 0, 1);
        chk("bp_head_stable", out_pc, 32'h300);
        step(0, 0, 0, 1, 0, 1);
        chk("bp_drain_second", out_pc, 32'h304);
        step(0, 0, 0, 1, 0, 1);
        chk("bp_drain_empty", out_valid, 1'b0);

        // Flush with two queued plus a simultaneous illegal push.
        step(1, 32'h00500093, 32'h400, 0, 0, 1);
        step(1, 32'h402081B3, 32'h404, 0, 0, 1);
        saved = illegal_count;
        step(1, 32'h00000000, 32'h408, 1, 1, 1);
        chk("flush_empty", out_valid, 1'b0);
        chk("flush_no_count", illegal_count, saved);
        step(1, 32'h12345237, 32'h40C, 1, 0, 1);
        chk("post_flush_pc", out_pc, 32'h40C);
        step(0, 0, 0, 1, 0, 1);

        // Randomized traffic including occasional flush and reset.
        for (int c = 0; c < 800; c++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                ins[6:0] = ops[$urandom_range(0, 7)];
                if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
                if ($urandom_range(0, 2) == 0) ins[14:12] = 3'b010;
            end
            step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 149) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised instruction decoder that sits between fetch and the register-file/execute stage. It decodes RV32I instructions into control fields and a sign-extended immediate, and flags illegal encodings. Decoded results are held in a small FIFO with valid/ready handshakes on both sides. It also provides a pipeline flush and a saturating illegal-instruction counter.

## Interface
Parameters:
- DEPTH, 2: decoded-entry FIFO depth; power of two, ≥2.
- ENABLE_MEM, 1: decode LW/SW; when 0 they are illegal.
- ENABLE_JUMP, 1: decode JAL/JALR; when 0 they are illegal.
- CNT_WIDTH, 16: illegal-counter width.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: reset, synchronous, active-low.
- flush, in, 1: discard all queued entries.
- in_valid / in_ready, in / out, 1 each: instruction handshake.
- in_instr, in, 32: instruction word, decoded with instruction_type field layout.
- in_pc, in, 32: PC of the instruction.
- out_valid / out_ready, out / in, 1 each: decoded handshake.
- out_pc, out, 32: PC of the head entry.
- out_rs1, out_rs2, out_rd, out, 5 each: register fields of the head entry.
- out_encoding, out, encoding_type: R/I/S/B/U/J type.
- out_alu_op, out, ALU op type: ALU_* value.
- out_reg_write, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_jump, out, 1 each: control bits.
- out_imm, out, 32: sign-extended immediate.
- out_illegal, out, 1: head entry is an illegal encoding.
- illegal_count, out, CNT_WIDTH: saturating count of illegal instructions accepted.

## Operation
- Decoding is combinational on in_instr. The result is written into the FIFO on accept (in_valid && in_ready). Outputs show the FIFO head.
- Opcode map:
  - 0110011: R-type. reg_write=1, alu_src=0.
  - 0010011: I-type. reg_write=1, alu_src=1.
  - 0110111 (LUI): U-type. reg_write=1, ALU_LUI.
  - 1100011: B-type. branch=1.
  - 0000011, funct3 010 (LW): I-type. reg_write=1, alu_src=1, mem_read=1, mem_to_reg=1, ALU_ADD.
  - 0100011, funct3 010 (SW): S-type. alu_src=1, mem_write=1, ALU_ADD.
  - 1101111 (JAL): J-type. jump=1, reg_write=1.
  - 1100111, funct3 000 (JALR): I-type. jump=1, reg_write=1, alu_src=1, ALU_ADD.
- ALU mapping:
  - ADD/ADDI → ALU_ADD; SUB → ALU_SUB.
  - SLL(I) → ALU_SLL; SRL(I) → ALU_SRL; SRA(I) → ALU_SRA.
  - XOR(I) → ALU_XOR; OR(I) → ALU_OR; AND(I) → ALU_AND.
  - SLT(I) → ALU_SLT; SLTU/SLTIU → ALU_SLTU.
  - BEQ/BNE → ALU_SUB; BLT/BGE → ALU_SLT; BLTU/BGEU → ALU_SLTU.
- Immediate: standard RV32I I/S/B/U/J formats, sign-extended from bit 31. U-type is {instr[31:12], 12'b0}. R-type immediate is 0.
- An instruction is illegal if any of the following holds:
  - unlisted opcode;
  - R-type funct7 other than 0000000, or 0100000 with a funct3 other than 000/101;
  - shift-immediate funct7 invalid (SLLI requires 0000000; SRLI/SRAI require 0000000/0100000);
  - branch funct3 010 or 011;
  - load/store funct3 ≠ 010;
  - JALR funct3 ≠ 000;
  - a decode-path opcode whose ENABLE_* parameter is 0.
- An illegal entry is still queued. All its control bits are 0, alu_op=ALU_ADD, imm=0, illegal=1.
- illegal_count increments by 1 on each accepted illegal instruction. It saturates at all-ones and is not cleared by flush.

## Timing
- Reset (rst=0 at a clock edge):
  - FIFO empties; out_valid=0.
  - illegal_count=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - All out_* data fields read 0 while empty.
- Latency: an accepted instruction appears at the head with out_valid=1 one cycle after acceptance, provided the FIFO was empty.
- in_ready = (occupancy ≠ DEPTH). It is registered state only and has no combinational path from out_ready.
- out_valid = (occupancy ≠ 0). The head is popped on out_valid && out_ready.
- Simultaneous push and pop leaves occupancy unchanged; pointers wrap modulo DEPTH. Throughput is one instruction per cycle when out_ready is held high.
- Full: in_ready=0. in_instr is ignored until a pop occurs; in_ready rises the cycle after the pop.
- Empty: out_ready is ignored and no underflow occurs.
- Out_* values are stable while out_valid && !out_ready.
- flush=1: occupancy is 0 on the next cycle. A push in the same cycle is discarded and is not counted as illegal. A pop in that cycle is a no-op.
- Reset takes priority over flush. Reset mid-transfer drops all entries.

## Test plan
- addi x1,x0,5 (0x00500093), out_ready=1:
  - one cycle later: out_valid=1, I-type, ALU_ADD, alu_src=1, reg_write=1, rd=1, imm=5.
- sub x3,x1,x2 (0x402081B3), then beq x1,x2,-4 (0xFE208EE3):
  - sub: ALU_SUB, R-type.
  - beq: branch=1, ALU_SUB, imm=0xFFFFFFFC.
  - back-to-back entries with no bubble.
- lw x5,8(x2) (0x00812283) and lui x4,0x12345 (0x12345237):
  - lw: mem_read=1, mem_to_reg=1, imm=8.
  - lui: ALU_LUI, imm=0x12345000.
  - repeat with ENABLE_MEM=0: lw gives illegal=1.
- 0x00000000 then 0xFFFFFFFF:
  - both illegal with all control bits 0.
  - illegal_count=2.
  - with CNT_WIDTH=2, six illegal instructions leave the count at 3.
- Backpressure with out_ready=0, DEPTH=2:
  - third in_valid sees in_ready=0.
  - head is held stable.
  - raising out_ready drains in order with no loss or duplication.
- Flush with 2 entries queued plus a simultaneous push:
  - next cycle out_valid=0.
  - illegal_count unchanged.
  - a subsequent push appears after 1 cycle.
